shift_seq_unit: RTL and testbench
=================================

# shift_seq_unit

Sequential shift unit for the datapath. It merges shift-input source selection and the shift itself into one clocked block. On `start` it captures one of `N_SRC` operand sources, then shifts or rotates it by one bit per cycle for `shamt` cycles and pulses `done`. The result is held on `data_out` for writeback. It replaces the standalone 4:1 shift-input selector feeding the shift register, and adds rotate modes, a start/busy/done handshake, and parametrised width and source count.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `N_SRC`, 4: number of selectable operand sources (≥2).
- `SEL_W`, $clog2(N_SRC): width of `src_sel`.
- `SHAMT_W`, $clog2(WIDTH): width of `shamt`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `src_sel`  in  SEL_W  operand source index.
- `data_in`  in  N_SRC*WIDTH  flattened sources; source i = `data_in[i*WIDTH +: WIDTH]`.
- `shamt`  in  SHAMT_W  shift amount, 0..WIDTH-1.
- `op`  in  3  operation code.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `data_out`  out  WIDTH  shift register contents.

## Operation
- **Op codes:**
  - 000 LOAD: no shift.
  - 001 SLL: zero fill.
  - 010 SRL: zero fill.
  - 011 SRA: MSB replicated.
  - 100 ROL.
  - 101 ROR.
  - 110 and 111 behave as LOAD.
- **Source select:** `src_sel` ≥ N_SRC selects all-zero.
- **FSM states:** IDLE, SHIFT, DONE.
  - IDLE, `start`=1: latch selected source into the data register, `shamt` into the counter, `op` into the op register.
    - Go to DONE if `shamt`=0 or op is LOAD-class.
    - Otherwise go to SHIFT.
  - IDLE, `start`=0: stay; the register holds its value.
  - SHIFT: each cycle, shift the register by 1 per the latched op and decrement the counter. When the counter goes 1→0, go to DONE.
  - DONE: `done`=1 for this cycle only, then go to IDLE. The register is unchanged.
- **Captured inputs:** `src_sel`, `data_in`, `shamt` and `op` are used only at the start edge. Changes while busy have no effect.
- **Start while busy:** `start` in SHIFT or DONE is ignored and not queued.
- **`data_out`:** always reflects the register. Intermediate values are visible during SHIFT. The final result is stable from the DONE cycle until the next accepted `start`.
- **Reset:** any cycle with `reset`=0 forces IDLE at that edge.
  - Data register = 0, counter = 0, op = LOAD, `busy`=0, `done`=0.
  - Reset mid-SHIFT aborts with no `done` pulse.
  - Reset dominates a coincident `start`.
- **Arithmetic:** no widening. Bits shifted out are discarded (SLL/SRL/SRA) or wrapped (ROL/ROR). There is no carry output.

## Timing
- Accepted `start` in cycle 0 gives `done`=1 in cycle k+1, where k = `shamt` for shift ops, and k=0 for `shamt`=0 or LOAD-class ops.
- `busy`=1 in cycles 1..k+1 and is 0 again in cycle k+2.
- Minimum interval between accepted starts is k+2 cycles; the next `start` is accepted in cycle k+2.
- `done` and `busy` are registered state decodes with no combinational path from inputs.
- `data_out` equals the fully shifted result in the cycle `done`=1.
- Worst case: `shamt`=WIDTH-1 gives `done` at cycle WIDTH.

## Test plan
- **Reset values:** hold `reset`=0 two cycles with random inputs and `start`=1 → `data_out`=0, `busy`=0, `done`=0; no start accepted.
- **SLL:** source 1 = 0x0000_0001, `src_sel`=1, `shamt`=4, op SLL, start at cycle 0 → `busy` cycles 1–5, `done` at cycle 5 only, `data_out`=0x0000_0010.
- **SRA full range:** source 0 = 0x8000_0000, `shamt`=31 → `done` at cycle 32, `data_out`=0xFFFF_FFFF. Repeat with SRL → 0x0000_0001.
- **ROR and ROL:** source 2 = 0x0000_0001, ROR by 1 → 0x8000_0000 at cycle 2. ROL 0x8000_0001 by 4 → 0x0000_0018.
- **Zero shift:** `shamt`=0 and LOAD with op 111, source 3 = 0xDEAD_BEEF → `done` at cycle 1, `data_out`=0xDEAD_BEEF. `src_sel`=5 with N_SRC=5 (param override) → 0.
- **Hazards:**
  - `start` with new operands during SHIFT → ignored; result unchanged.
  - `reset`=0 at cycle 3 of an 8-cycle SLL → IDLE, `data_out`=0, no `done` pulse.
  - `start` in cycle k+2 after a completed op → accepted.

Source files
------------

// File: rtl/shift_seq_unit.sv
// Sequential shift unit: captures one of N_SRC operands on start, then shifts or
// rotates it one bit per cycle for shamt cycles and pulses done on completion.
module shift_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int N_SRC   = 4,
    parameter int SEL_W   = $clog2(N_SRC),
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [N_SRC*WIDTH-1:0] data_in,
    input  logic [SHAMT_W-1:0]     shamt,
    input  logic [2:0]             op,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                r_op;
    op_t                w_op_nxt;
    op_t                w_op_in;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]   w_step;
    logic [SHAMT_W-1:0] r_cnt;
    logic [SHAMT_W-1:0] w_cnt_nxt;
    logic               w_load_class;

    assign w_op_in = op_t'(op);

    // Out-of-range indices fall through to the all-zero default.
    always_comb begin
        w_src = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (32'(src_sel) == i) begin
                w_src = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_load_class = (w_op_in == OP_LOAD) || (w_op_in == OP_RSV6) ||
                       (w_op_in == OP_RSV7);
    end

    // Single-bit step applied once per SHIFT cycle using the latched op.
    always_comb begin
        w_step = r_data;
        case (r_op)
            OP_SLL:  w_step = {r_data[WIDTH-2:0], 1'b0};
            OP_SRL:  w_step = {1'b0, r_data[WIDTH-1:1]};
            OP_SRA:  w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            OP_ROL:  w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            OP_ROR:  w_step = {r_data[0], r_data[WIDTH-1:1]};
            default: w_step = r_data;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_data_nxt = w_src;
                    w_cnt_nxt  = shamt;
                    w_op_nxt   = w_op_in;
                    if ((shamt == '0) || w_load_class) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_data_nxt = w_step;
                w_cnt_nxt  = r_cnt - 1'b1;
                if (r_cnt == SHAMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= OP_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign data_out = r_data;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: expected result and latency are queued at
// launch and checked when done appears; a second instance uses N_SRC=5.
module tb_shift_seq_unit;

    localparam int WIDTH   = 32;
    localparam int N_SRC   = 4;
    localparam int SEL_W   = 2;
    localparam int SHAMT_W = 5;
    localparam int N_SRC2  = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               lat;
    } exp_t;

    logic                    clk     = 1'b0;
    logic                    reset   = 1'b0;
    logic                    start   = 1'b0;
    logic [SEL_W-1:0]        src_sel = '0;
    logic [WIDTH-1:0]        src [N_SRC];
    logic [N_SRC*WIDTH-1:0]  data_in;
    logic [SHAMT_W-1:0]      shamt   = '0;
    logic [2:0]              op      = '0;
    logic                    busy;
    logic                    done;
    logic [WIDTH-1:0]        data_out;

    logic                    start2   = 1'b0;
    logic [2:0]              src_sel2 = '0;
    logic [WIDTH-1:0]        src2 [N_SRC2];
    logic [N_SRC2*WIDTH-1:0] data_in2;
    logic                    busy2;
    logic                    done2;
    logic [WIDTH-1:0]        data_out2;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) data_in[i*WIDTH +: WIDTH] = src[i];
    end

    always_comb begin
        for (int j = 0; j < N_SRC2; j++) data_in2[j*WIDTH +: WIDTH] = src2[j];
    end

    shift_seq_unit #(.WIDTH(WIDTH), .N_SRC(N_SRC)) dut (
        .clk(clk), .reset(reset), .start(start), .src_sel(src_sel),
        .data_in(data_in), .shamt(shamt), .op(op),
        .busy(busy), .done(done), .data_out(data_out)
    );

    shift_seq_unit #(.WIDTH(WIDTH), .N_SRC(N_SRC2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .src_sel(src_sel2),
        .data_in(data_in2), .shamt(shamt), .op(op),
        .busy(busy2), .done(done2), .data_out(data_out2)
    );

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v,
                                               input int sh, input logic [2:0] o);
        logic [2*WIDTH-1:0] dbl;
        case (o)
            3'd1: return v << sh;
            3'd2: return v >> sh;
            3'd3: return WIDTH'($signed(v) >>> sh);
            3'd4: begin dbl = {v, v} << sh; return dbl[2*WIDTH-1:WIDTH]; end
            3'd5: begin dbl = {v, v} >> sh; return dbl[WIDTH-1:0]; end
            default: return v;
        endcase
    endfunction

    function automatic int lat_of(input int sh, input logic [2:0] o);
        if (o == 3'd0 || o == 3'd6 || o == 3'd7 || sh == 0) return 1;
        return sh + 1;
    endfunction

    // Called at a negedge; the following posedge is cycle 0's accepting edge.
    task automatic launch(input int sel, input int sh, input logic [2:0] o);
        exp_t e;
        e.data = model(src[sel], sh, o);
        e.lat  = lat_of(sh, o);
        sb.push_back(e);
        src_sel = SEL_W'(sel);
        shamt   = SHAMT_W'(sh);
        op      = o;
        start   = 1'b1;
    endtask

    task automatic await_done(input string tag, input int haz);
        exp_t e;
        bit   seen;
        int   cyc;
        e    = sb[0];
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < WIDTH + 4) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s_busy cycle %0d: got %b want 1", tag, cyc, busy);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                void'(sb.pop_front());
                n_cmp++;
                if (cyc != e.lat) begin
                    n_err++;
                    $display("FAIL %s_latency: got %0d want %0d", tag, cyc, e.lat);
                end
                n_cmp++;
                if (data_out !== e.data) begin
                    n_err++;
                    $display("FAIL %s_data: got %h want %h", tag, data_out, e.data);
                end
            end
            if (cyc == haz) begin
                start   = 1'b1;
                src_sel = SEL_W'($urandom);
                shamt   = SHAMT_W'($urandom);
                op      = 3'($urandom);
                for (int i = 0; i < N_SRC; i++) src[i] = $urandom;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles want cycle %0d", tag, cyc, e.lat);
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            src_sel = SEL_W'($urandom);
            shamt   = SHAMT_W'($urandom);
            op      = 3'($urandom);
            for (int i = 0; i < N_SRC; i++) src[i] = $urandom;
            @(negedge clk);
            n_cmp++;
            if (data_out !== '0) begin
                n_err++;
                $display("FAIL reset_data: got %h want 0", data_out);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_busy: got %b want 0", busy);
            end
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_done: got %b want 0", done);
            end
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || data_out !== '0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b data=%h want busy=0 data=0", busy, data_out);
        end
    endtask

    task automatic test_sll();
        src[1] = 32'h0000_0001;
        launch(1, 4, 3'b001);
        await_done("sll", 0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0000_0010) begin
            n_err++;
            $display("FAIL sll_after: got busy=%b done=%b data=%h want 0 0 00000010",
                     busy, done, data_out);
        end
    endtask

    task automatic test_sra_full();
        src[0] = 32'h8000_0000;
        launch(0, 31, 3'b011);
        await_done("sra31", 0);
        @(negedge clk);
        launch(0, 31, 3'b010);
        await_done("srl31", 0);
        @(negedge clk);
    endtask

    task automatic test_rotate();
        src[2] = 32'h0000_0001;
        launch(2, 1, 3'b101);
        await_done("ror1", 0);
        @(negedge clk);
        src[2] = 32'h8000_0001;
        launch(2, 4, 3'b100);
        await_done("rol4", 0);
        @(negedge clk);
    endtask

    task automatic test_zero_shift();
        src[3] = 32'hDEAD_BEEF;
        launch(3, 0, 3'b001);
        await_done("zero_sh", 0);
        @(negedge clk);
        launch(3, 5, 3'b111);
        await_done("load111", 0);
        @(negedge clk);
        n_cmp++;
        if (data_out !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL load_hold: got %h want deadbeef", data_out);
        end
    endtask

    task automatic test_src_range();
        exp_t e;
        int   sels [3];
        sels[0] = 5;
        sels[1] = 4;
        sels[2] = 7;
        for (int j = 0; j < N_SRC2; j++) src2[j] = 32'hA5A5_0000 | 32'(j + 1);
        for (int k = 0; k < 3; k++) begin
            e.data = (sels[k] < N_SRC2) ? src2[sels[k]] : '0;
            e.lat  = 1;
            sb.push_back(e);
            src_sel2 = 3'(sels[k]);
            shamt    = '0;
            op       = 3'b000;
            start2   = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (done2 !== 1'b1 || data_out2 !== e.data) begin
                n_err++;
                $display("FAIL src_range sel=%0d: got done=%b data=%h want done=1 data=%h",
                         sels[k], done2, data_out2, e.data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        src[1] = 32'h0000_0003;
        launch(1, 8, 3'b001);
        await_done("haz_start", 3);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || data_out !== 32'h0000_0300) begin
                n_err++;
                $display("FAIL haz_not_queued: got busy=%b data=%h want busy=0 data=00000300",
                         busy, data_out);
            end
        end
    endtask

    task automatic test_reset_abort();
        src[0] = 32'h0000_00FF;
        launch(0, 8, 3'b001);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL abort_pre cycle %0d: got busy=%b done=%b want 1 0", c, busy, done);
            end
            if (c == 3) reset = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== '0) begin
            n_err++;
            $display("FAIL abort_reset: got busy=%b done=%b data=%h want 0 0 0",
                     busy, done, data_out);
        end
        void'(sb.pop_front());
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_done: got busy=%b done=%b want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        src[2] = 32'h8000_0001;
        src[1] = 32'h8000_0000;
        launch(2, 4, 3'b100);
        await_done("b2b_first", 0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
        launch(1, 3, 3'b010);
        await_done("b2b_second", 0);
        @(negedge clk);
    endtask

    task automatic test_random_ops();
        int sel;
        int sh;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N_SRC; i++) src[i] = $urandom;
            sel = $urandom_range(N_SRC - 1, 0);
            sh  = $urandom_range(WIDTH - 1, 0);
            launch(sel, sh, 3'($urandom));
            await_done("random", 0);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < N_SRC; i++) src[i] = '0;
        for (int j = 0; j < N_SRC2; j++) src2[j] = '0;
        test_reset();
        test_sll();
        test_sra_full();
        test_rotate();
        test_zero_shift();
        test_src_range();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        test_random_ops();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
